// File: rtl/tl_err_pkg.sv
// tl_err_pkg: TileLink opcodes, arbiter state and D beat-count helper for the error arbiter
package tl_err_pkg;
  localparam logic [2:0] A_GET = 3'd4;
  localparam logic [2:0] D_ACCESS_ACK = 3'd0;
  localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;
  localparam logic [2:0] D_GRANT = 3'd4;
  localparam logic [2:0] D_GRANT_DATA = 3'd5;
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  function automatic logic [3:0] beats_for(input logic [2:0] opcode, input logic [1:0] size, input int beat_lg);
    return ((opcode == D_ACCESS_ACK_DATA || opcode == D_GRANT_DATA) && int'(size) > beat_lg) ? 4'(1 << (int'(size) - beat_lg)) : 4'd1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after the pointer
module rr_arbiter #(
  parameter int N = 2,
  localparam int IW = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx
);
  logic [N-1:0] w_rot;
  logic [IW-1:0] w_off;
  logic [IW:0] w_sum;
  // rotate so the pointer sits at bit 0, then take the lowest set bit as the distance
  always_comb begin
    w_rot = N'({i_req, i_req} >> i_ptr);
    w_off = '0;
    for (int k = N - 1; k >= 0; k--) if (w_rot[k]) w_off = IW'(k);
  end
  assign w_sum = {1'b0, i_ptr} + {1'b0, w_off};
  assign o_idx = w_sum >= (IW+1)'(N) ? IW'(w_sum - (IW+1)'(N)) : w_sum[IW-1:0];
  assign o_gnt = |i_req ? N'(1) << o_idx : '0;
endmodule

// File: rtl/tl_error_arbiter.sv
// tl_error_arbiter: round-robin, one-in-flight sharing of a TileLink error device with a response watchdog
module tl_error_arbiter import tl_err_pkg::*; #(
  parameter int NUM_IN = 2,
  parameter int ADDR_W = 128,
  parameter int BEAT_LG = 1,
  parameter int TIMEOUT = 255,
  localparam int IW = NUM_IN > 1 ? $clog2(NUM_IN) : 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_IN-1:0]          in_a_valid,
  output logic [NUM_IN-1:0]          in_a_ready,
  input  logic [3*NUM_IN-1:0]        in_a_opcode,
  input  logic [2*NUM_IN-1:0]        in_a_size,
  input  logic [ADDR_W*NUM_IN-1:0]   in_a_address,
  output logic [NUM_IN-1:0]          in_d_valid,
  input  logic [NUM_IN-1:0]          in_d_ready,
  output logic [2:0]                 in_d_opcode,
  output logic [1:0]                 in_d_param,
  output logic [1:0]                 in_d_size,
  output logic                       in_d_denied,
  output logic                       in_d_corrupt,
  output logic                       out_a_valid,
  input  logic                       out_a_ready,
  output logic [2:0]                 out_a_opcode,
  output logic [1:0]                 out_a_size,
  output logic [ADDR_W-1:0]          out_a_address,
  input  logic                       out_d_valid,
  output logic                       out_d_ready,
  input  logic [2:0]                 out_d_opcode,
  input  logic [1:0]                 out_d_param,
  input  logic [1:0]                 out_d_size,
  input  logic                       out_d_denied,
  input  logic                       out_d_corrupt,
  output logic [IW-1:0]              owner,
  output logic                       busy,
  output logic                       timeout_err
);
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);
  state_t r_state;
  logic [IW-1:0] r_owner;
  logic [IW-1:0] r_rr_ptr;
  logic [2:0] r_beat_cnt;
  logic r_started;
  logic r_timeout_err;
  logic [7:0] r_wd;
  logic [2:0] w_opc [NUM_IN];
  logic [1:0] w_size [NUM_IN];
  logic [ADDR_W-1:0] w_addr [NUM_IN];
  logic [NUM_IN-1:0] w_gnt;
  logic [IW-1:0] w_idx;
  logic [IW-1:0] w_next_ptr;
  logic [3:0] w_beats;
  logic w_d_hs;
  logic w_last;
  for (genvar g = 0; g < NUM_IN; g++) begin : g_unpack
    assign w_opc[g] = in_a_opcode[3*g +: 3];
    assign w_size[g] = in_a_size[2*g +: 2];
    assign w_addr[g] = in_a_address[ADDR_W*g +: ADDR_W];
  end
  rr_arbiter #(.N(NUM_IN)) u_rr (
    .i_req(in_a_valid),
    .i_ptr(r_rr_ptr),
    .o_gnt(w_gnt),
    .o_idx(w_idx)
  );
  assign w_d_hs = r_state == RESP && out_d_valid && out_d_ready;
  assign w_beats = beats_for(out_d_opcode, out_d_size, BEAT_LG);
  assign w_last = r_started ? r_beat_cnt == 3'd1 : w_beats == 4'd1;
  assign w_next_ptr = r_owner == IW'(NUM_IN - 1) ? '0 : r_owner + 1'b1;
  assign out_a_valid = r_state == ISSUE && in_a_valid[r_owner];
  assign out_a_opcode = w_opc[r_owner];
  assign out_a_size = w_size[r_owner];
  assign out_a_address = w_addr[r_owner];
  assign in_a_ready = r_state == ISSUE ? NUM_IN'(out_a_ready) << r_owner : '0;
  assign in_d_valid = r_state == RESP ? NUM_IN'(out_d_valid) << r_owner : '0;
  assign out_d_ready = r_state == RESP ? in_d_ready[r_owner] : r_state == IDLE && !reset;
  assign in_d_opcode = out_d_opcode;
  assign in_d_param = out_d_param;
  assign in_d_size = out_d_size;
  assign in_d_denied = out_d_denied;
  assign in_d_corrupt = out_d_corrupt;
  assign owner = r_owner;
  assign busy = r_state != IDLE;
  assign timeout_err = r_timeout_err;
  // grant lock from arbitration through the last D beat; beat_cnt holds beats still owed after the first
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_rr_ptr <= '0;
      r_owner <= '0;
      r_beat_cnt <= '0;
      r_started <= 1'b0;
      r_wd <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= 1'b0;
      case (r_state)
        IDLE: if (|w_gnt) begin
          r_owner <= w_idx;
          r_state <= ISSUE;
        end
        ISSUE: if (!in_a_valid[r_owner]) r_state <= IDLE;
        else if (out_a_ready) begin
          r_state <= RESP;
          r_rr_ptr <= w_next_ptr;
          r_wd <= '0;
          r_started <= 1'b0;
          r_beat_cnt <= '0;
        end
        RESP: if (w_d_hs) begin
          r_wd <= '0;
          r_started <= !w_last;
          r_beat_cnt <= w_last ? 3'd0 : r_started ? r_beat_cnt - 3'd1 : 3'(w_beats - 4'd1);
          if (w_last) r_state <= IDLE;
        end else if (r_wd == WD_LAST) begin
          r_state <= IDLE;
          r_timeout_err <= 1'b1;
          r_started <= 1'b0;
          r_beat_cnt <= '0;
          r_wd <= r_wd + 8'd1;
        end else r_wd <= r_wd + 8'd1;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tl_error_arbiter.sv
// tb_tl_error_arbiter: scenario tasks plus randomized traffic checked against a transaction-level model
module tb_tl_error_arbiter;
  localparam int NI = 2;
  localparam int AW = 128;
  localparam int BL = 1;
  localparam int TO = 10;
  logic clock = 1'b0;
  logic reset;
  logic [NI-1:0] in_a_valid, in_a_ready, in_d_valid, in_d_ready;
  logic [3*NI-1:0] in_a_opcode;
  logic [2*NI-1:0] in_a_size;
  logic [AW*NI-1:0] in_a_address;
  logic [2:0] in_d_opcode, out_a_opcode, out_d_opcode;
  logic [1:0] in_d_param, in_d_size, out_a_size, out_d_param, out_d_size;
  logic in_d_denied, in_d_corrupt, out_a_valid, out_a_ready, out_d_valid, out_d_ready, out_d_denied, out_d_corrupt;
  logic [AW-1:0] out_a_address;
  logic [0:0] owner;
  logic busy, timeout_err;
  int errs = 0;
  int checks = 0;
  int m_ptr = 0;

  tl_error_arbiter #(.NUM_IN(NI), .ADDR_W(AW), .BEAT_LG(BL), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .in_a_valid(in_a_valid), .in_a_ready(in_a_ready), .in_a_opcode(in_a_opcode),
    .in_a_size(in_a_size), .in_a_address(in_a_address),
    .in_d_valid(in_d_valid), .in_d_ready(in_d_ready), .in_d_opcode(in_d_opcode),
    .in_d_param(in_d_param), .in_d_size(in_d_size), .in_d_denied(in_d_denied), .in_d_corrupt(in_d_corrupt),
    .out_a_valid(out_a_valid), .out_a_ready(out_a_ready), .out_a_opcode(out_a_opcode),
    .out_a_size(out_a_size), .out_a_address(out_a_address),
    .out_d_valid(out_d_valid), .out_d_ready(out_d_ready), .out_d_opcode(out_d_opcode),
    .out_d_param(out_d_param), .out_d_size(out_d_size), .out_d_denied(out_d_denied), .out_d_corrupt(out_d_corrupt),
    .owner(owner), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  function automatic int exp_grant(input logic [NI-1:0] v, input int p);
    for (int k = 0; k < NI; k++) if (((v >> ((p + k) % NI)) & 1) != 0) return (p + k) % NI;
    return -1;
  endfunction

  function automatic int exp_beats(input int opc, input int size);
    return ((opc == 1 || opc == 5) && size > BL) ? 2 ** (size - BL) : 1;
  endfunction

  function automatic logic [AW-1:0] rnd_addr();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    in_a_valid = '0; in_d_ready = '0; in_a_opcode = '0; in_a_size = '0; in_a_address = '0;
    out_a_ready = 1'b0; out_d_valid = 1'b0; out_d_opcode = '0; out_d_param = '0;
    out_d_size = '0; out_d_denied = 1'b0; out_d_corrupt = 1'b0;
  endtask

  task automatic set_a(input int r, input logic [2:0] opc, input logic [1:0] sz, input logic [AW-1:0] addr);
    in_a_opcode[3*r +: 3] = opc;
    in_a_size[2*r +: 2] = sz;
    in_a_address[AW*r +: AW] = addr;
  endtask

  task automatic set_d(input logic [2:0] opc, input logic [1:0] sz, input logic den);
    out_d_opcode = opc; out_d_size = sz; out_d_denied = den;
    out_d_param = 2'($urandom); out_d_corrupt = 1'($urandom);
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    in_a_valid = '1;
    step(); step();
    checks++; if ({busy, in_a_ready, in_d_valid, out_a_valid, out_d_ready, timeout_err} !== 8'd0) begin errs++; $display("FAIL reset_outputs: got %b want 0", {busy, in_a_ready, in_d_valid, out_a_valid, out_d_ready, timeout_err}); end
    checks++; if (int'(owner) !== 0) begin errs++; $display("FAIL reset_owner: got %0d want 0", owner); end
    in_a_valid = '0;
    reset = 1'b0;
    m_ptr = 0;
    step();
    checks++; if ({busy, out_d_ready} !== 2'b01) begin errs++; $display("FAIL reset_release: busy,out_d_ready got %b want 01", {busy, out_d_ready}); end
  endtask

  task automatic test_single_get();
    logic [AW-1:0] a;
    int n, e;
    a = rnd_addr();
    n = exp_beats(1, 3);
    e = exp_grant(2'b01, m_ptr);
    set_a(0, 3'd4, 2'd3, a);
    in_a_valid = 2'b01; out_a_ready = 1'b1;
    #1;
    checks++; if ({in_a_ready, out_a_valid, busy} !== 4'd0) begin errs++; $display("FAIL get_no_comb_ready: got %b want 0", {in_a_ready, out_a_valid, busy}); end
    step();
    checks++; if (int'(owner) !== e || busy !== 1'b1) begin errs++; $display("FAIL get_grant: owner %0d busy %b want %0d 1", owner, busy, e); end
    checks++; if ({out_a_valid, out_a_opcode, out_a_size, in_a_ready} !== {1'b1, 3'd4, 2'd3, 2'b01} || out_a_address !== a) begin errs++; $display("FAIL get_issue: v %b opc %0d sz %0d rdy %b want 1 4 3 01", out_a_valid, out_a_opcode, out_a_size, in_a_ready); end
    step();
    m_ptr = (e + 1) % NI;
    in_a_valid = '0;
    set_d(3'd1, 2'd3, 1'b1);
    out_d_valid = 1'b1; in_d_ready = 2'b11;
    for (int c = 0; c < n; c++) begin
      #1;
      checks++; if ({in_d_valid, in_d_denied, in_d_opcode, busy} !== {2'b01, 1'b1, 3'd1, 1'b1} || in_d_param !== out_d_param) begin errs++; $display("FAIL get_beat%0d: dv %b den %b opc %0d busy %b want 01 1 1 1", c, in_d_valid, in_d_denied, in_d_opcode, busy); end
      step();
    end
    checks++; if ({busy, in_d_valid, out_d_ready} !== 4'b0001) begin errs++; $display("FAIL get_end: busy,dv,dr got %b want 0001", {busy, in_d_valid, out_d_ready}); end
    out_d_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    int e;
    set_a(0, 3'd0, 2'd2, rnd_addr());
    set_a(1, 3'd0, 2'd2, rnd_addr());
    in_a_valid = 2'b11; out_a_ready = 1'b1; in_d_ready = 2'b11;
    for (int t = 0; t < 4; t++) begin
      e = exp_grant(2'b11, m_ptr);
      #1;
      checks++; if ({busy, in_a_ready} !== 3'd0) begin errs++; $display("FAIL b2b_gap%0d: busy,ar got %b want 000", t, {busy, in_a_ready}); end
      step();
      checks++; if (int'(owner) !== e || in_a_ready !== NI'(1 << e)) begin errs++; $display("FAIL b2b_grant%0d: owner %0d ar %b want %0d", t, owner, in_a_ready, e); end
      step();
      m_ptr = (e + 1) % NI;
      set_d(3'd0, 2'd2, 1'b1);
      out_d_valid = 1'b1;
      #1;
      checks++; if (in_d_valid !== NI'(1 << e)) begin errs++; $display("FAIL b2b_ack%0d: dv %b want owner %0d", t, in_d_valid, e); end
      step();
      out_d_valid = 1'b0;
    end
    in_a_valid = '0;
  endtask

  task automatic test_backpressure();
    logic rd, ar;
    int n, got;
    n = exp_beats(1, 3);
    got = 0;
    set_a(1, 3'd4, 2'd3, rnd_addr());
    in_a_valid = 2'b10;
    step();
    checks++; if (int'(owner) !== 1) begin errs++; $display("FAIL bp_grant: owner %0d want 1", owner); end
    for (int c = 0; c < 8; c++) begin
      ar = (c == 7) ? 1'b1 : 1'($urandom);
      out_a_ready = ar;
      #1;
      checks++; if (in_a_ready !== {ar, 1'b0}) begin errs++; $display("FAIL bp_a_ready: got %b want %b", in_a_ready, {ar, 1'b0}); end
      step();
      if (ar) break;
    end
    m_ptr = 0;
    in_a_valid = '0;
    set_d(3'd1, 2'd3, 1'($urandom));
    out_d_valid = 1'b1;
    for (int c = 0; c < 40 && got < n; c++) begin
      rd = (c == 1) ? 1'b0 : (c % 3 == 0) ? 1'b1 : 1'($urandom);
      in_d_ready = {rd, ~rd};
      #1;
      checks++; if ({in_d_valid, out_d_ready, in_d_opcode} !== {2'b10, rd, 3'd1}) begin errs++; $display("FAIL bp_beat: dv %b dr %b opc %0d want 10 %b 1", in_d_valid, out_d_ready, in_d_opcode, rd); end
      if (rd) got++;
      step();
    end
    checks++; if (got !== n) begin errs++; $display("FAIL bp_count: beats %0d want %0d", got, n); end
    #1;
    checks++; if ({busy, in_d_valid, out_d_ready} !== 4'b0001) begin errs++; $display("FAIL bp_drop_extra: busy,dv,dr got %b want 0001", {busy, in_d_valid, out_d_ready}); end
    out_d_valid = 1'b0;
  endtask

  task automatic test_timeout();
    set_a(0, 3'd4, 2'd1, rnd_addr());
    in_a_valid = 2'b01; out_a_ready = 1'b1; in_d_ready = 2'b11;
    step(); step();
    m_ptr = 1;
    in_a_valid = '0;
    for (int c = 0; c < TO; c++) begin
      checks++; if ({busy, timeout_err} !== 2'b10) begin errs++; $display("FAIL to_wait%0d: busy,err got %b want 10", c, {busy, timeout_err}); end
      step();
    end
    checks++; if ({busy, timeout_err} !== 2'b01) begin errs++; $display("FAIL to_pulse: busy,err got %b want 01", {busy, timeout_err}); end
    set_d(3'd1, 2'd1, 1'b1);
    out_d_valid = 1'b1;
    #1;
    checks++; if ({out_d_ready, in_d_valid} !== 3'b100) begin errs++; $display("FAIL to_late_drop: dr,dv got %b want 100", {out_d_ready, in_d_valid}); end
    step();
    out_d_valid = 1'b0;
    checks++; if (timeout_err !== 1'b0) begin errs++; $display("FAIL to_one_shot: err got %b want 0", timeout_err); end
    set_a(1, 3'd4, 2'd0, rnd_addr());
    in_a_valid = 2'b10;
    step();
    checks++; if (int'(owner) !== exp_grant(2'b10, m_ptr) || out_a_valid !== 1'b1) begin errs++; $display("FAIL to_regrant: owner %0d av %b want 1 1", owner, out_a_valid); end
    step();
    m_ptr = 0;
    in_a_valid = '0;
    set_d(3'd0, 2'd0, 1'b1);
    out_d_valid = 1'b1;
    #1;
    checks++; if (in_d_valid !== 2'b10) begin errs++; $display("FAIL to_regrant_ack: dv %b want 10", in_d_valid); end
    step();
    out_d_valid = 1'b0;
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL to_regrant_end: busy %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    set_a(0, 3'd4, 2'd3, rnd_addr());
    in_a_valid = 2'b01; out_a_ready = 1'b1; in_d_ready = 2'b01;
    step(); step();
    in_a_valid = '0;
    set_d(3'd1, 2'd3, 1'b1);
    out_d_valid = 1'b1;
    #1;
    checks++; if (in_d_valid !== 2'b01) begin errs++; $display("FAIL rst_beat1: dv %b want 01", in_d_valid); end
    step();
    reset = 1'b1;
    step();
    checks++; if ({busy, in_a_ready, in_d_valid, out_a_valid, out_d_ready, timeout_err, owner} !== 9'd0) begin errs++; $display("FAIL rst_mid_outputs: got %b want 0", {busy, in_a_ready, in_d_valid, out_a_valid, out_d_ready, timeout_err, owner}); end
    reset = 1'b0;
    m_ptr = 0;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++; if ({busy, in_d_valid, out_d_ready} !== 4'b0001) begin errs++; $display("FAIL rst_drain%0d: busy,dv,dr got %b want 0001", c, {busy, in_d_valid, out_d_ready}); end
      step();
    end
    out_d_valid = 1'b0;
  endtask

  task automatic test_acquire();
    int n;
    n = exp_beats(5, 2);
    set_a(1, 3'd6, 2'd2, rnd_addr());
    in_a_valid = 2'b10; out_a_ready = 1'b1; in_d_ready = 2'b11;
    step();
    checks++; if (int'(owner) !== 1 || out_a_opcode !== 3'd6 || in_a_ready !== 2'b10) begin errs++; $display("FAIL acq_issue: owner %0d opc %0d ar %b want 1 6 10", owner, out_a_opcode, in_a_ready); end
    step();
    m_ptr = 0;
    set_a(0, 3'd4, 2'd0, rnd_addr());
    in_a_valid = 2'b01;
    set_d(3'd5, 2'd2, 1'b1);
    out_d_valid = 1'b1;
    for (int c = 0; c < n; c++) begin
      #1;
      checks++; if ({in_d_valid, in_d_opcode} !== {2'b10, 3'd5}) begin errs++; $display("FAIL acq_beat%0d: dv %b opc %0d want 10 5", c, in_d_valid, in_d_opcode); end
      step();
    end
    out_d_valid = 1'b0; out_a_ready = 1'b0;
    #1;
    checks++; if ({busy, in_a_ready} !== 3'd0) begin errs++; $display("FAIL acq_idle_gap: busy,ar got %b want 000", {busy, in_a_ready}); end
    step();
    checks++; if (busy !== 1'b1 || int'(owner) !== exp_grant(2'b01, m_ptr)) begin errs++; $display("FAIL acq_next_grant: busy %b owner %0d want 1 0", busy, owner); end
    in_a_valid = '0;
    #1;
    checks++; if (out_a_valid !== 1'b0) begin errs++; $display("FAIL abort_av: got %b want 0", out_a_valid); end
    step();
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL abort_idle: busy %b want 0", busy); end
    in_a_valid = 2'b11;
    step();
    checks++; if (int'(owner) !== exp_grant(2'b11, m_ptr)) begin errs++; $display("FAIL abort_ptr_kept: owner %0d want %0d", owner, exp_grant(2'b11, m_ptr)); end
    in_a_valid = '0;
    step();
  endtask

  task automatic test_random();
    logic [AW-1:0] addrs [NI];
    logic [NI-1:0] v;
    logic ar, rd;
    int e, n, got, dop, dsz;
    for (int it = 0; it < 30; it++) begin
      v = NI'($urandom_range(1, (1 << NI) - 1));
      for (int r = 0; r < NI; r++) begin
        addrs[r] = rnd_addr();
        set_a(r, 3'($urandom), 2'($urandom), addrs[r]);
      end
      in_a_valid = v;
      e = exp_grant(v, m_ptr);
      step();
      checks++; if (int'(owner) !== e || busy !== 1'b1) begin errs++; $display("FAIL rnd_grant%0d: owner %0d busy %b want %0d 1", it, owner, busy, e); end
      for (int c = 0; c < 6; c++) begin
        ar = (c == 5) ? 1'b1 : 1'($urandom);
        out_a_ready = ar;
        #1;
        checks++; if (in_a_ready !== NI'(ar) << e || out_a_address !== addrs[e]) begin errs++; $display("FAIL rnd_issue%0d: ar %b addr %0h want owner %0d", it, in_a_ready, out_a_address, e); end
        step();
        if (ar) break;
      end
      m_ptr = (e + 1) % NI;
      in_a_valid = '0;
      dop = (($urandom % 2) != 0 ? 1 : 0) + (($urandom % 2) != 0 ? 4 : 0);
      dsz = int'($urandom % 4);
      n = exp_beats(dop, dsz);
      got = 0;
      set_d(3'(dop), 2'(dsz), 1'b1);
      out_d_valid = 1'b1;
      for (int c = 0; c < 40 && got < n; c++) begin
        rd = (c % 3 == 0) ? 1'b1 : 1'($urandom);
        in_d_ready = (NI'($urandom) & ~(NI'(1) << e)) | (NI'(rd) << e);
        #1;
        checks++; if (in_d_valid !== NI'(1 << e) || out_d_ready !== rd) begin errs++; $display("FAIL rnd_beat%0d: dv %b dr %b want owner %0d ready %b", it, in_d_valid, out_d_ready, e, rd); end
        if (rd) got++;
        step();
      end
      out_d_valid = 1'b0;
      checks++; if (got !== n || busy !== 1'b0) begin errs++; $display("FAIL rnd_end%0d: beats %0d busy %b want %0d 0", it, got, busy, n); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: bench did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_get();
    test_back_to_back();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_acquire();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
